// File: rtl/probe_pkg.sv
// probe_pkg: shared state encoding and helpers for the probe channel scan sequencer.
package probe_pkg;
  typedef enum logic [1:0] {IDLE, GUARD, DWELL, OUT} state_t;
  function automatic int ch_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction
  function automatic logic [31:0] onehot(input logic [31:0] ch);
    return 32'd1 << ch;
  endfunction
endpackage

// File: rtl/probe_next_ch.sv
// probe_next_ch: rotating priority finder, next enabled channel strictly above i_ch with wrap flag.
module probe_next_ch #(
  parameter int N = 4,
  parameter int CH_W = 2
) (
  input  logic [N-1:0]    i_mask,
  input  logic [CH_W-1:0] i_ch,
  output logic [CH_W-1:0] o_ch,
  output logic            o_wrap
);
  logic [CH_W-1:0] w_hi, w_lo;
  logic            w_hi_found;
  // Descending sweep so the last hit in each class is the lowest index.
  always_comb begin
    w_hi = '0;
    w_lo = '0;
    w_hi_found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_mask[i] && i > int'(i_ch)) begin
        w_hi = CH_W'(i);
        w_hi_found = 1'b1;
      end
      if (i_mask[i]) w_lo = CH_W'(i);
    end
  end
  assign o_ch = w_hi_found ? w_hi : w_lo;
  assign o_wrap = !w_hi_found;
endmodule

// File: rtl/probe_scan_ctrl.sv
// probe_scan_ctrl: steps a one-hot probe mux select across masked channels with guard
// cycles and programmable dwell, emitting {channel, bit} samples over valid/ready.
module probe_scan_ctrl
  import probe_pkg::*;
#(
  parameter int N = 4,
  parameter int DW_W = 8,
  localparam int CH_W = ch_w(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            stop,
  input  logic            continuous,
  input  logic [N-1:0]    ch_mask,
  input  logic [DW_W-1:0] dwell,
  output logic [N-1:0]    sw,
  input  logic            mux_dout,
  output logic            smp_valid,
  input  logic            smp_ready,
  output logic [CH_W-1:0] smp_ch,
  output logic            smp_bit,
  output logic            busy,
  output logic            done
);
  state_t          r_state;
  logic [CH_W-1:0] r_ch;
  logic [N-1:0]    r_mask;
  logic [DW_W-1:0] r_dw, r_cnt;
  logic            r_cont, r_stop;
  logic [N-1:0]    w_mask;
  logic [CH_W-1:0] w_cur, w_next;
  logic            w_wrap;
  // In IDLE the finder starts from the top channel so it wraps to the lowest enabled one.
  assign w_mask = (r_state == IDLE) ? ch_mask : r_mask;
  assign w_cur = (r_state == IDLE) ? CH_W'(N - 1) : r_ch;
  probe_next_ch #(.N(N), .CH_W(CH_W)) u_next (
    .i_mask(w_mask),
    .i_ch(w_cur),
    .o_ch(w_next),
    .o_wrap(w_wrap)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_ch <= '0;
      r_mask <= '0;
      r_dw <= '0;
      r_cnt <= '0;
      r_cont <= 1'b0;
      r_stop <= 1'b0;
      sw <= '0;
      smp_valid <= 1'b0;
      smp_ch <= '0;
      smp_bit <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: if (start && !stop && |ch_mask) begin
          r_mask <= ch_mask;
          r_dw <= (dwell == '0) ? '0 : dwell - DW_W'(1);
          r_cont <= continuous;
          r_ch <= w_next;
          r_stop <= 1'b0;
          busy <= 1'b1;
          r_state <= GUARD;
        end
        GUARD: if (stop) begin
          busy <= 1'b0;
          done <= 1'b1;
          r_state <= IDLE;
        end else begin
          r_cnt <= r_dw;
          sw <= N'(onehot(32'(r_ch)));
          r_state <= DWELL;
        end
        DWELL: if (stop) begin
          sw <= '0;
          busy <= 1'b0;
          done <= 1'b1;
          r_state <= IDLE;
        end else if (r_cnt == '0) begin
          smp_bit <= mux_dout;
          smp_ch <= r_ch;
          smp_valid <= 1'b1;
          sw <= '0;
          r_state <= OUT;
        end else begin
          r_cnt <= r_cnt - DW_W'(1);
        end
        OUT: if (smp_ready) begin
          smp_valid <= 1'b0;
          r_ch <= w_next;
          if (r_stop || stop || (w_wrap && !r_cont)) begin
            busy <= 1'b0;
            done <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_state <= GUARD;
          end
        end else begin
          r_stop <= r_stop | stop;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_probe_scan_ctrl.sv
// tb_probe_scan_ctrl: directed scoreboard bench for probe_scan_ctrl with a behavioural mux model.
module tb_probe_scan_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       continuous = 1'b0;
  logic [3:0] ch_mask = '0;
  logic [7:0] dwell = '0;
  logic [3:0] sw;
  logic       mux_dout;
  logic       smp_valid;
  logic       smp_ready = 1'b0;
  logic [1:0] smp_ch;
  logic       smp_bit;
  logic       busy;
  logic       done;
  logic [3:0] pat = '0;
  logic [2:0] q[$];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;
  assign mux_dout = |(sw & pat);

  probe_scan_ctrl #(.N(4), .DW_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .continuous(continuous),
    .ch_mask(ch_mask), .dwell(dwell), .sw(sw), .mux_dout(mux_dout),
    .smp_valid(smp_valid), .smp_ready(smp_ready), .smp_ch(smp_ch),
    .smp_bit(smp_bit), .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic pop_cmp(input string tag);
    logic [2:0] e;
    chk({tag, "_avail"}, 32'(q.size() != 0), 1);
    if (q.size() != 0) begin
      e = q.pop_front();
      chk({tag, "_ch"}, 32'(smp_ch), 32'(e[2:1]));
      chk({tag, "_bit"}, 32'(smp_bit), 32'(e[0]));
    end
  endtask

  task automatic do_start(input logic [3:0] m, input logic [7:0] d, input logic c);
    ch_mask = m;
    dwell = d;
    continuous = c;
    start = 1'b1;
    if (!c)
      for (int i = 0; i < 4; i++)
        if (m[i]) q.push_back({2'(i), pat[i]});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!smp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_wait_valid"}, 32'(smp_valid), 1);
  endtask

  task automatic expect_sample(input string tag);
    int n = 0;
    while (!(smp_valid && smp_ready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_hs"}, 32'(smp_valid && smp_ready), 1);
    pop_cmp(tag);
    @(negedge clk);
  endtask

  task automatic run_scan(input string tag, input logic [3:0] exp_seen);
    logic [3:0] seen = '0;
    logic got_done = 1'b0;
    for (int n = 0; n < 300 && !got_done; n++) begin
      chk({tag, "_sw_legal"}, 32'($onehot0(sw)), 1);
      seen |= sw;
      if (smp_valid && smp_ready) pop_cmp(tag);
      got_done = done;
      @(negedge clk);
    end
    chk({tag, "_done"}, 32'(got_done), 1);
    chk({tag, "_seen"}, 32'(seen), 32'(exp_seen));
    chk({tag, "_q_empty"}, q.size(), 0);
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("rst_sw", 32'(sw), 0);
    chk("rst_valid", 32'(smp_valid), 0);
    chk("rst_ch", 32'(smp_ch), 0);
    chk("rst_bit", 32'(smp_bit), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    rst = 1'b0;
    @(negedge clk);

    pat = 4'b1101;
    smp_ready = 1'b1;
    do_start(4'b1111, 8'd3, 1'b0);
    for (int c = 0; c < 4; c++)
      for (int k = 0; k < 5; k++) begin
        chk("t1_sw", 32'(sw), (k == 0 || k == 4) ? 0 : (1 << c));
        chk("t1_busy", 32'(busy), 1);
        if (k == 4) begin
          chk("t1_valid", 32'(smp_valid), 1);
          pop_cmp("t1");
        end
        @(negedge clk);
      end
    chk("t1_done", 32'(done), 1);
    chk("t1_idle", 32'(busy), 0);
    @(negedge clk);
    chk("t1_done_pulse", 32'(done), 0);

    pat = 4'b1000;
    do_start(4'b1010, 8'd1, 1'b0);
    run_scan("t2", 4'b1010);

    pat = 4'b0001;
    smp_ready = 1'b0;
    do_start(4'b0001, 8'd2, 1'b0);
    wait_valid("t3");
    for (int k = 0; k < 5; k++) begin
      chk("t3_valid_hold", 32'(smp_valid), 1);
      chk("t3_ch_hold", 32'(smp_ch), 0);
      chk("t3_bit_hold", 32'(smp_bit), 1);
      chk("t3_sw_zero", 32'(sw), 0);
      @(negedge clk);
    end
    smp_ready = 1'b1;
    pop_cmp("t3");
    @(negedge clk);
    chk("t3_done", 32'(done), 1);
    chk("t3_valid_drop", 32'(smp_valid), 0);
    @(negedge clk);

    pat = 4'b0100;
    do_start(4'b0110, 8'd2, 1'b1);
    q.push_back({2'd1, pat[1]});
    q.push_back({2'd2, pat[2]});
    q.push_back({2'd1, pat[1]});
    expect_sample("t4_s0");
    expect_sample("t4_s1");
    expect_sample("t4_s2");
    for (int n = 0; n < 20 && sw != 4'b0100; n++) @(negedge clk);
    chk("t4_dwell_ch2", 32'(sw), 4);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("t4_stop_sw", 32'(sw), 0);
    chk("t4_stop_valid", 32'(smp_valid), 0);
    chk("t4_stop_done", 32'(done), 1);
    chk("t4_stop_busy", 32'(busy), 0);
    chk("t4_q_empty", q.size(), 0);
    @(negedge clk);

    pat = 4'b0001;
    smp_ready = 1'b0;
    do_start(4'b0001, 8'd1, 1'b1);
    wait_valid("t5");
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("t5_valid_hold0", 32'(smp_valid), 1);
    chk("t5_busy_hold", 32'(busy), 1);
    @(negedge clk);
    chk("t5_valid_hold1", 32'(smp_valid), 1);
    smp_ready = 1'b1;
    q.push_back({2'd0, 1'b1});
    pop_cmp("t5");
    @(negedge clk);
    chk("t5_done", 32'(done), 1);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_valid", 32'(smp_valid), 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t5_no_guard", 32'({busy, sw}), 0);
    end

    do_start(4'b0001, 8'd0, 1'b0);
    chk("t6_d0_guard", 32'(sw), 0);
    @(negedge clk);
    chk("t6_d0_dwell", 32'(sw), 1);
    @(negedge clk);
    chk("t6_d0_out_sw", 32'(sw), 0);
    chk("t6_d0_valid", 32'(smp_valid), 1);
    pop_cmp("t6_d0");
    @(negedge clk);
    chk("t6_d0_done", 32'(done), 1);

    do_start(4'b0000, 8'd3, 1'b0);
    for (int k = 0; k < 3; k++) begin
      chk("t6_m0_busy", 32'(busy), 0);
      chk("t6_m0_done", 32'(done), 0);
      @(negedge clk);
    end

    do_start(4'b0001, 8'd10, 1'b0);
    @(negedge clk);
    chk("t6_rst_pre_sw", 32'(sw), 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_sw", 32'(sw), 0);
    chk("t6_rst_valid", 32'(smp_valid), 0);
    chk("t6_rst_busy", 32'(busy), 0);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t6_rst_idle", 32'({busy, sw}), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
